// File: rtl/mac_array_ctrl.sv
// Job sequencer for MAC_array: clears the array, streams DMA beats into it,
// waits out the array pipeline and hands the dot product to a result port.
module mac_array_ctrl #(
    parameter int BEATS_W = 8,
    parameter int MAC_LAT = 2,
    parameter int ACC_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [BEATS_W-1:0] cfg_beats,
    input  logic [ACC_W-1:0]   cfg_bias,
    output logic               cfg_err,
    input  logic               dma_valid,
    output logic               dma_ready,
    output logic               mac_en,
    output logic               mac_clr,
    output logic [ACC_W-1:0]   mac_bias,
    output logic               mac_read_en,
    input  logic [ACC_W-1:0]   mac_dot,
    output logic               res_valid,
    output logic [ACC_W-1:0]   res_data,
    input  logic               res_ready,
    output logic               busy
);

    localparam int DRAIN_W = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t               state_q;
    logic [BEATS_W-1:0]   beats_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic [ACC_W-1:0]     bias_q;
    logic [ACC_W-1:0]     res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beats_q <= '0;
            drain_q <= '0;
            bias_q  <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid && (cfg_beats != '0)) begin
                        beats_q <= cfg_beats;
                        bias_q  <= cfg_bias;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (dma_valid) begin
                        beats_q <= beats_q - BEATS_W'(1);
                        if (beats_q == BEATS_W'(1)) begin
                            drain_q <= DRAIN_W'(MAC_LAT);
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q - DRAIN_W'(1);
                    // The array output is valid on the last drain cycle.
                    if (drain_q == DRAIN_W'(1)) begin
                        res_q   <= mac_dot;
                        state_q <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // mac_en stays combinational so the array samples the channels in the beat's own cycle.
    assign cfg_ready   = (state_q == S_IDLE);
    assign cfg_err     = (state_q == S_IDLE) && cfg_valid && (cfg_beats == '0);
    assign dma_ready   = (state_q == S_STREAM);
    assign mac_en      = (state_q == S_STREAM) && dma_valid;
    assign mac_clr     = (state_q == S_CLEAR);
    assign mac_bias    = bias_q;
    assign mac_read_en = (state_q == S_DRAIN) && (drain_q == DRAIN_W'(1));
    assign res_valid   = (state_q == S_OUTPUT);
    assign res_data    = res_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: job table driven against a stub MAC_array,
// results checked through an in-order scoreboard queue.
module tb_mac_array_ctrl;

    localparam int BEATS_W = 8;
    localparam int MAC_LAT = 2;
    localparam int ACC_W   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [BEATS_W-1:0] cfg_beats;
    logic [ACC_W-1:0]   cfg_bias;
    logic               cfg_err;
    logic               dma_valid;
    logic               dma_ready;
    logic               mac_en;
    logic               mac_clr;
    logic [ACC_W-1:0]   mac_bias;
    logic               mac_read_en;
    logic [ACC_W-1:0]   mac_dot;
    logic               res_valid;
    logic [ACC_W-1:0]   res_data;
    logic               res_ready;
    logic               busy;

    mac_array_ctrl #(
        .BEATS_W(BEATS_W),
        .MAC_LAT(MAC_LAT),
        .ACC_W  (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_beats  (cfg_beats),
        .cfg_bias   (cfg_bias),
        .cfg_err    (cfg_err),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .mac_bias   (mac_bias),
        .mac_read_en(mac_read_en),
        .mac_dot    (mac_dot),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Array stub: dot product is only meaningful exactly MAC_LAT cycles after the last en.
    logic [ACC_W-1:0] stub_val = '0;
    logic             en_d1 = 1'b0;
    logic             en_d2 = 1'b0;
    always @(posedge clk) begin
        en_d1 <= mac_en;
        en_d2 <= en_d1;
    end
    assign mac_dot = (en_d2 && !en_d1) ? stub_val : 16'hDEAD;

    int tests = 0;
    int fails = 0;
    logic [ACC_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    typedef struct {
        int          beats;
        logic [15:0] bias;
        logic [15:0] dot;
        int          stall_at;
        int          stall_len;
        int          bp;
        int          exp_res;
    } vec_t;

    vec_t vecs[7];

    task automatic check_reset_values();
        chk("reset_1bit_outputs",
            {cfg_ready, busy, dma_ready, mac_en, mac_clr, mac_read_en, res_valid, cfg_err},
            8'b1000_0000);
        chk("reset_res_data", res_data, 16'h0000);
        chk("reset_mac_bias", mac_bias, 16'h0000);
    endtask

    // Entered in an IDLE cycle just after a negedge; returns in the following IDLE cycle.
    task automatic run_job(input vec_t v);
        int k;
        int en_cnt = 0;
        int clr_cnt = 0;
        int clr_k = 0;
        int rd_k = 0;
        int res_k = 0;
        int bad_win = 0;
        int bad_bp = 0;
        int bad_bias = 0;
        logic done = 1'b0;
        logic [ACC_W-1:0] first = '0;
        logic [ACC_W-1:0] want;

        cfg_valid = 1'b1;
        cfg_beats = BEATS_W'(v.beats);
        cfg_bias  = v.bias;
        stub_val  = v.dot;
        dma_valid = 1'b1;
        res_ready = 1'b0;
        #1;
        chk("job_offer_cfg_ready", cfg_ready, 1'b1);
        chk("job_offer_cfg_err", cfg_err, 1'b0);
        exp_q.push_back(v.dot);

        for (k = 1; k <= v.exp_res + v.bp + 20 && !done; k++) begin
            @(negedge clk);
            // Junk descriptors during the job must be ignored.
            cfg_valid = (k % 3 == 0);
            cfg_beats = 8'd5;
            cfg_bias  = 16'hBEEF;
            dma_valid = !(k >= v.stall_at && k < v.stall_at + v.stall_len);
            res_ready = (k >= v.exp_res + v.bp);
            #1;
            if (dma_ready !== (k >= 2 && en_cnt < v.beats)) bad_win++;
            if (mac_en !== (dma_ready && dma_valid)) bad_win++;
            if (cfg_ready !== 1'b0 || busy !== 1'b1 || cfg_err !== 1'b0) bad_win++;
            if (mac_bias !== v.bias) bad_bias++;
            if (mac_en === 1'b1) en_cnt++;
            if (mac_clr === 1'b1) begin
                clr_cnt++;
                clr_k = k;
            end
            if (mac_read_en === 1'b1) rd_k = k;
            if (res_valid === 1'b1) begin
                if (res_k == 0) begin
                    res_k = k;
                    first = res_data;
                end
                if (res_data !== first || mac_en !== 1'b0) bad_bp++;
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_nonempty", 32'd0, 32'd1);
                    end else begin
                        want = exp_q.pop_front();
                        chk("res_data", res_data, want);
                    end
                    done = 1'b1;
                end
            end
        end

        chk("res_handshake_seen", done, 1'b1);
        chk("mac_en_count", en_cnt, v.beats);
        chk("mac_clr_count", clr_cnt, 1);
        chk("mac_clr_cycle", clr_k, 1);
        chk("mac_read_en_cycle", rd_k, v.exp_res - 1);
        chk("res_valid_cycle", res_k, v.exp_res);
        chk("stream_window_errs", bad_win, 0);
        chk("backpressure_errs", bad_bp, 0);
        chk("mac_bias_errs", bad_bias, 0);

        @(negedge clk);
        cfg_valid = 1'b0;
        res_ready = 1'b0;
        dma_valid = 1'b1;
        #1;
        chk("idle_after_accept", {cfg_ready, busy, res_valid, mac_en}, 4'b1000);
        chk("mac_bias_held", mac_bias, v.bias);
    endtask

    initial begin
        int bad;
        vecs[0] = '{beats: 4,   bias: 16'h0010, dot: 16'h1234, stall_at: 0, stall_len: 0, bp: 0, exp_res: 8};
        vecs[1] = '{beats: 3,   bias: 16'h0011, dot: 16'h1234, stall_at: 3, stall_len: 2, bp: 0, exp_res: 9};
        vecs[2] = '{beats: 4,   bias: 16'h0020, dot: 16'h4321, stall_at: 0, stall_len: 0, bp: 5, exp_res: 8};
        vecs[3] = '{beats: 7,   bias: 16'hABCD, dot: 16'h5A5A, stall_at: 4, stall_len: 3, bp: 2, exp_res: 14};
        vecs[4] = '{beats: 1,   bias: 16'h0001, dot: 16'h0F0F, stall_at: 0, stall_len: 0, bp: 0, exp_res: 5};
        vecs[5] = '{beats: 255, bias: 16'h00FF, dot: 16'h0FF0, stall_at: 0, stall_len: 0, bp: 0, exp_res: 259};
        vecs[6] = '{beats: 2,   bias: 16'h0002, dot: 16'h2222, stall_at: 0, stall_len: 0, bp: 0, exp_res: 6};

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_beats = '0;
        cfg_bias  = '0;
        dma_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        // Zero-length descriptor.
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_beats = '0;
        cfg_bias  = 16'h5555;
        #1;
        chk("zero_len_cfg_err", cfg_err, 1'b1);
        chk("zero_len_cfg_ready", cfg_ready, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        chk("zero_len_err_pulse", {cfg_err, busy, mac_clr}, 3'b000);
        @(negedge clk);
        #1;
        chk("zero_len_no_job", {busy, mac_clr, cfg_ready}, 3'b001);
        chk("zero_len_bias_unlatched", mac_bias, 16'h0000);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] job %0d: beats=%0d bias=%0h", i, vecs[i].beats, vecs[i].bias);
            run_job(vecs[i]);
        end

        // Reset in the middle of a 6-beat job, after 2 beats.
        cfg_valid = 1'b1;
        cfg_beats = 8'd6;
        cfg_bias  = 16'h0077;
        dma_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        dma_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        dma_valid = 1'b1;
        #1;
        check_reset_values();
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (res_valid !== 1'b0 || mac_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("abandoned_job_quiet", bad, 0);

        run_job(vecs[6]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
- Sequencer for MAC_array: accepts a dot-product job descriptor (beat count, bias).
- Clears the array, then streams the four 64-bit DMA channels into it beat by beat under a valid/ready handshake.
- Waits out the array pipeline, then captures dot_product and presents it on a valid/ready result port.
- Sits between the DMA front-end and MAC_array.

Parameters:
- BEATS_W, 8: width of the beat counter; max job length is 2^BEATS_W-1 beats.
- MAC_LAT, 2: cycles from the last mac_en beat to dot_product valid (>=1).
- ACC_W, 16: width of bias and dot_product.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  controller can accept a job.
- cfg_beats  in  BEATS_W  number of DMA beats (4x64 bits each) in the job.
- cfg_bias  in  ACC_W  bias for this job.
- cfg_err  out  1  one-cycle pulse when a zero-length job is offered.
- dma_valid  in  1  all four DMA channels hold valid data this cycle.
- dma_ready  out  1  controller consumes a beat this cycle.
- mac_en  out  1  to MAC_array en.
- mac_clr  out  1  to MAC_array clr.
- mac_bias  out  ACC_W  to MAC_array bias.
- mac_read_en  out  1  to MAC_array read_en.
- mac_dot  in  ACC_W  from MAC_array dot_product.
- res_valid  out  1  result available.
- res_data  out  ACC_W  captured dot product.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; beat counter and drain counter=0; res_data=0, mac_bias=0. All 1-bit outputs are 0 except cfg_ready=1.
- Reset mid-job abandons the job: no res_valid, no further mac_en.
- Handshakes complete on the clock edge where valid&&ready=1. Inputs may change freely while ready=0.
- IDLE:
  - cfg_ready=1.
  - cfg_valid=1 with cfg_beats!=0: latch beats and bias (mac_bias updates next cycle), go to CLEAR.
  - cfg_valid=1 with cfg_beats==0: cfg_err=1 for that cycle, descriptor consumed, stay IDLE.
- CLEAR: mac_clr=1 for exactly one cycle, cfg_ready=0, go to STREAM.
- STREAM:
  - dma_ready=1. mac_en=dma_valid, combinational, so the array samples the channels in the same cycle.
  - Each accepted beat decrements the remaining count.
  - dma_valid=0 is a stall: mac_en=0, state held.
  - On the accepted beat where remaining==1, go to DRAIN with drain counter=MAC_LAT.
- DRAIN:
  - dma_ready=0, mac_en=0.
  - Counter decrements each cycle. mac_read_en=1 on the cycle the counter equals 1.
  - On that cycle, capture res_data<=mac_dot and go to OUTPUT.
- OUTPUT:
  - res_valid=1; res_data stable until accepted.
  - res_ready=0 holds indefinitely.
  - On acceptance go to IDLE; cfg_ready rises the next cycle, giving one idle bubble between jobs.
- Latency, no stalls, accept at cycle T:
  - CLEAR at T+1.
  - Beats at T+2..T+N+1.
  - res_valid first high at T+N+MAC_LAT+2.
- Arithmetic is limited to the down-counters. The controller never modifies mac_dot.
- mac_bias holds the latched value from CLEAR until the next job is latched.
- cfg_valid outside IDLE is ignored (cfg_ready=0).
- dma_valid outside STREAM is ignored and never reaches mac_en.
- Max length job (cfg_beats=2^BEATS_W-1) must complete with no counter wrap.

Test Plan:
- The MAC_array model is a stub returning mac_dot=16'h1234, valid MAC_LAT cycles after the last en.
- Basic job: cfg_beats=4, cfg_bias=16'h0010, dma_valid held 1, res_ready=1 -> one mac_clr pulse at T+1, mac_en high T+2..T+5, mac_read_en at T+7, res_valid at T+8 with res_data=16'h1234, mac_bias=16'h0010.
- Stall: cfg_beats=3, dma_valid low for 2 cycles after the first beat -> exactly 3 mac_en cycles, res_valid at T+9, dma_ready low outside STREAM.
- Back-pressure: res_ready=0 for 5 cycles after res_valid -> res_data constant, cfg_ready=0, no mac_en. On res_ready=1, IDLE next cycle.
- Zero-length job: cfg_valid with cfg_beats=0 -> single-cycle cfg_err, no mac_clr, busy stays 0.
- Reset mid-STREAM after 2 of 6 beats -> next cycle all outputs at reset values, no res_valid. A new job with cfg_beats=2 then completes normally.
- Back-to-back jobs of 1 and 255 beats -> two results in order, 1 and 255 mac_en pulses respectively, no counter wrap.
